// File: rtl/nibble_add_sched_pkg.sv
// nibble_add_sched_pkg: shared state enum, nibble width, default size and requester-id type
package nibble_add_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  localparam int DEFAULT_NIBBLES = 4;
  typedef logic req_id_t;
endpackage

// File: rtl/nibble_adder.sv
// nibble_adder: 4-bit ripple-carry adder of four full-adder cells (a, b, cin -> s, cout)
module nibble_adder
  import nibble_add_sched_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);
  logic [NIBBLE_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_add_sched.sv
// nibble_add_sched: round-robin shares one nibble adder between req0/req1 (valid/ready, a, b, cin) and returns {rsp_cout, rsp_s}, rsp_id on a valid/ready response port
module nibble_add_sched
  import nibble_add_sched_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] req0_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] req0_b,
  input  logic                       req0_cin,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] req1_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] req1_b,
  input  logic                       req1_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [NIBBLE_W*NIBBLES-1:0] rsp_s,
  output logic                       rsp_cout
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t          state_q, state_d;
  req_id_t         last_q, last_d, id_q, id_d, grant;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d, acc, nib_c;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [NIBBLE_W-1:0] nib_s;
  assign grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = state_q == IDLE && grant == 1'b0 && !rst;
  assign req1_ready = state_q == IDLE && grant == 1'b1 && !rst;
  assign acc        = grant ? req1_valid && req1_ready : req0_valid && req0_ready;
  nibble_adder u_add (
    .a    (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .b    (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (state_q == IDLE && acc) begin
      state_d = RUN;
      a_d     = grant ? req1_a : req0_a;
      b_d     = grant ? req1_b : req0_b;
      carry_d = grant ? req1_cin : req0_cin;
      last_d  = grant;
      id_d    = grant;
      idx_d   = '0;
      sum_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_s;
      carry_d = nib_c;
      state_d = idx_q == IW'(NIBBLES - 1) ? DONE : RUN;
      idx_d   = idx_q == IW'(NIBBLES - 1) ? '0 : idx_q + 1'b1;
    end else if (state_q == DONE && rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end
  assign rsp_valid = state_q == DONE;
  assign rsp_s     = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_nibble_add_sched.sv
// tb_nibble_add_sched: directed scoreboard bench for nibble_add_sched with NIBBLES=4
module tb_nibble_add_sched;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req0_cin = 0, req1_valid = 0, req1_cin = 0, rsp_ready = 1;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout;
  logic [15:0] rsp_s;
  typedef struct {logic id; logic [15:0] s; logic cout; int acc;} exp_t;
  exp_t sb[$];
  exp_t rlog[$];
  logic gnt[$];
  int total = 0, bad = 0, cyc = 0, acc_n = 0, rv_start = 0, last_acc = 0, cons_cyc = 0;
  logic rv_prev = 0;
  nibble_add_sched #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic push(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    sb.push_back('{id, t[15:0], t[16], cyc});
    gnt.push_back(id);
    acc_n++;
    last_acc = cyc;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && req0_valid && req0_ready) push(1'b0, req0_a, req0_b, req0_cin);
    if (!rst && req1_valid && req1_ready) push(1'b1, req1_a, req1_b, req1_cin);
    if (rsp_valid && !rv_prev) rv_start = cyc;
    rv_prev = rsp_valid;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_id", rsp_id, e.id);
        chk("sb_s", rsp_s, e.s);
        chk("sb_cout", rsp_cout, e.cout);
        chk("latency", rv_start - e.acc, 5);
        rlog.push_back('{rsp_id, rsp_s, rsp_cout, cyc});
        cons_cyc = cyc;
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic [15:0] a, input logic [15:0] b, input logic cin);
    req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1;
  endtask
  task automatic set1(input logic [15:0] a, input logic [15:0] b, input logic cin);
    req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1;
  endtask
  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_n < target && n < 60) begin step(1); n++; end
    if (acc_n < target) chk("accept_timeout", acc_n, target);
  endtask
  task automatic drop_last;
    if (gnt.size() > 0 && gnt[$] == 1'b0) req0_valid = 0;
    else req1_valid = 0;
  endtask
  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin step(1); n++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask
  task automatic chk_log(input int i, input logic id, input logic [15:0] s, input logic cout);
    if (rlog.size() > i) begin
      chk($sformatf("log%0d_id", i), rlog[i].id, id);
      chk($sformatf("log%0d_s", i), rlog[i].s, s);
      chk($sformatf("log%0d_cout", i), rlog[i].cout, cout);
    end else chk($sformatf("log%0d_missing", i), rlog.size(), i + 1);
  endtask
  task automatic chk_gnt(input int i, input logic id);
    if (gnt.size() > i) chk($sformatf("grant%0d", i), gnt[i], id);
    else chk($sformatf("grant%0d_missing", i), gnt.size(), i + 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, nresp;
    logic [15:0] hs;
    step(2);
    set0(16'h1234, 16'h0FCD, 1'b0);
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_id", rsp_id, 0);
    step(1);
    rst = 0;
    wait_acc(1); req0_valid = 0; drain;
    chk_log(0, 1'b0, 16'h2201, 1'b0);
    set1(16'hFFFF, 16'h0000, 1'b1);
    wait_acc(2); req1_valid = 0; drain;
    chk_log(1, 1'b1, 16'h0000, 1'b1);
    rst = 1;
    set0(16'h0001, 16'h0001, 1'b0);
    set1(16'h8000, 16'h8000, 1'b0);
    step(2);
    rst = 0;
    wait_acc(3); drop_last;
    wait_acc(4); drop_last;
    drain;
    chk_gnt(2, 1'b0);
    chk_gnt(3, 1'b1);
    chk_log(2, 1'b0, 16'h0002, 1'b0);
    chk_log(3, 1'b1, 16'h0000, 1'b1);
    set0(16'h0010, 16'h0020, 1'b0);
    set1(16'h0F00, 16'h0100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_acc(5 + k);
      if (gnt.size() > 0 && gnt[$] == 1'b0) set0(16'($urandom), 16'($urandom), 1'($urandom));
      else set1(16'($urandom), 16'($urandom), 1'($urandom));
    end
    req0_valid = 0; req1_valid = 0;
    drain;
    chk_gnt(4, 1'b0); chk_gnt(5, 1'b1); chk_gnt(6, 1'b0); chk_gnt(7, 1'b1);
    rsp_ready = 0;
    set0(16'hABCD, 16'h1234, 1'b1);
    wait_acc(9); req0_valid = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(1); n++; end
    chk("bp_valid_seen", rsp_valid, 1);
    set1(16'h0505, 16'h0A0A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_s", rsp_s, 16'hBE02);
      chk("bp_cout", rsp_cout, 0);
      chk("bp_id", rsp_id, 0);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 0);
    end
    rsp_ready = 1;
    wait_acc(10); req1_valid = 0;
    chk("bp_next_accept", last_acc - cons_cyc, 1);
    drain;
    set0(16'h5555, 16'h1111, 1'b0);
    wait_acc(11); req0_valid = 0;
    step(2);
    rst = 1;
    #1;
    chk("midrst_req0_ready", req0_ready, 0);
    chk("midrst_req1_ready", req1_ready, 0);
    step(1);
    rst = 0;
    sb.delete();
    nresp = rlog.size();
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_s", rsp_s, 0);
    chk("midrst_rsp_cout", rsp_cout, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    step(8);
    chk("midrst_no_rsp", rlog.size(), nresp);
    set0(16'h00FF, 16'h0001, 1'b0);
    wait_acc(12); req0_valid = 0; drain;
    hs = 16'h0100;
    chk_log(nresp, 1'b0, hs, 1'b0);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_add_sched.md
# nibble_add_sched

Round-robin scheduler that shares one 4-bit ripple adder slice between two requesters and performs multi-precision addition nibble-serially. Each accepted request adds two `4*NIBBLES`-bit operands plus a carry-in. The adder slice is reused once per nibble, least-significant first, with the inter-nibble carry held in a register. The block sits between two operand producers and a single result consumer, replacing a wide parallel adder where area matters more than latency.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width is `W = 4*NIBBLES`; legal range 1..16.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `req0_valid`, input, 1: requester 0 presents operands.
- `req0_ready`, output, 1: scheduler accepts requester 0 this cycle.
- `req0_a`, `req0_b`, input, W: requester 0 operands.
- `req0_cin`, input, 1: requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `rsp_valid`, output, 1: result available.
- `rsp_ready`, input, 1: consumer takes the result.
- `rsp_id`, output, 1: index of the requester that owns the result.
- `rsp_s`, output, W: sum.
- `rsp_cout`, output, 1: final carry-out.

## Operation
- States: IDLE, RUN, DONE.
- **Arbitration in IDLE:**
  - `last` pointer holds the last-granted id; reset value 1, so req0 wins the first contest.
  - Single valid requester: it is granted.
  - Both valid: the requester that is not `last` is granted.
  - `reqN_ready = (state==IDLE) && grant==N && !rst`. This is combinational from the valids and does not depend on `rsp_ready`.
- **Accept:** `valid && ready` on the granted requester.
  - Latch A, B, cin and id.
  - Set `last` to the granted id.
  - Set `idx` to 0 and `carry` to cin.
  - Go to RUN.
- **RUN**, once per cycle:
  - Adder inputs: `A[4*idx+:4]`, `B[4*idx+:4]`, `carry`.
  - Write the 4-bit sum into `sum[4*idx+:4]`.
  - Load the adder's carry-out into `carry`.
  - If `idx == NIBBLES-1`, go to DONE; otherwise increment `idx`.
- **DONE:**
  - `rsp_valid = 1`; `rsp_s`, `rsp_cout` and `rsp_id` are stable.
  - On `rsp_ready`, go to IDLE.
  - Both `reqN_ready` are low.
- **Arithmetic:**
  - `{rsp_cout, rsp_s} = A + B + cin`, evaluated modulo `2^(W+1)`.
  - Operands are unsigned; there is no overflow flag.
- **Reset values:**
  - state IDLE, `last` = 1, `idx` = 0, `carry` = 0.
  - `rsp_valid` = 0, `rsp_s` = 0, `rsp_cout` = 0, `rsp_id` = 0.
  - Both `reqN_ready` are 0 while `rst` is high.
- **Reset mid-operation:** an operation in RUN or DONE is discarded, no response is produced, and the state returns to IDLE on the next edge.
- **Requester drops valid without ready:** nothing is latched and the grant is re-evaluated next cycle. Requesters must nevertheless hold valid until accepted.

## Timing
- Accept edge is E0. RUN occupies the NIBBLES cycles after E0.
- `rsp_valid` rises in cycle E0+NIBBLES+1, i.e. latency NIBBLES+1 cycles from accept.
- With `rsp_ready` tied high, the response is consumed in its first cycle. The next accept can then occur in the following IDLE cycle, giving a minimum period of NIBBLES+2 cycles per operation.
- The response is held indefinitely under backpressure; no new request is accepted until it is consumed.
- `reqN_ready` depends only on state, `last`, the valids and `rst`. There is no path from `rsp_ready` to `reqN_ready` within the same cycle.

## Structure
- Shared package:
  - state enum (IDLE, RUN, DONE)
  - `NIBBLE_W = 4`
  - default `NIBBLES`
  - the requester-id type
- One sub-module, `nibble_adder`:
  - combinational 4-bit ripple-carry adder built from four full-adder cells
  - ports: a[4], b[4], cin, s[4], cout
  - instantiated exactly once
- Everything else (arbiter, `idx` counter, operand and sum registers, FSM) lives in `nibble_add_sched`.

## Test plan
All scenarios use `NIBBLES=4`.
- Single operation: req0 0x1234 + 0x0FCD, cin 0 → `rsp_s` 0x2201, `rsp_cout` 0, `rsp_id` 0; `rsp_valid` exactly 5 cycles after the accept edge.
- Carry chain: req1 0xFFFF + 0x0000, cin 1 → `rsp_s` 0x0000, `rsp_cout` 1, `rsp_id` 1.
- Contention: both valid from reset with req0 0x0001+0x0001 and req1 0x8000+0x8000 → first response id 0, sum 0x0002, cout 0; second response id 1, sum 0x0000, cout 1.
- Fairness: the next simultaneous request after the contention scenario goes to req0. Then with both held valid continuously, grants alternate 0,1,0,1.
- Backpressure: hold `rsp_ready` low for 5 cycles in DONE → `rsp_valid` stays high with `rsp_s`/`rsp_cout`/`rsp_id` unchanged, both `reqN_ready` low. After `rsp_ready` is raised, the next accept occurs in the following cycle.
- Reset mid-RUN: assert `rst` for 1 cycle when `idx` = 2 → no response. All outputs return to their reset values. A following req0 0x00FF+0x0001 returns 0x0100, cout 0, with normal latency.
